fifo_muxer_ctrl: RTL and testbench

Main-data read sequencer for the MP3 decoder. It sits between the bit-reservoir FIFO (one bit per read) and the four scalefactor parsers plus the Huffman decoder. For each frame it:
- discards stale reservoir bits according to `main_data_begin`;
- walks granule/channel slots gr0ch0, gr0ch1, gr1ch0, gr1ch1;
- routes each slot's bits first to its scalefactor parser (part2), then to the Huffman decoder for the rest of `part2_3_length`.

---
 rtl/fifo_muxer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fifo_muxer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_muxer_ctrl.sv
// Main-data read sequencer: drops stale reservoir bits, then walks the four
// granule/channel slots, routing bits to the scalefactor parser and then to Huffman.
module fifo_muxer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fifo_sample_count,
  input  logic        fifo_dout_v,
  input  logic        si_valid_in,
  input  logic [8:0]  main_data_begin,
  input  logic [47:0] part2_3_length,
  input  logic [3:0]  sf_parser_axiov,
  output logic        sf_parser_flag,
  output logic        hf_decoder_flag,
  output logic        gr,
  output logic        ch,
  output logic        fifo_rd_en,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISCARD = 3'd1,
    S_SF      = 3'd2,
    S_HF      = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_gr;
  logic        r_ch;
  logic        w_gr_next;
  logic        w_ch_next;
  logic [15:0] r_discard;
  logic [15:0] w_discard_next;
  logic [11:0] r_p2cnt;
  logic [11:0] w_p2cnt_next;
  logic [11:0] r_hf_rem;
  logic [11:0] w_hf_rem_next;
  logic [47:0] r_len;
  logic        w_len_load;

  logic [11:0] w_len_arr [4];
  logic [1:0]  w_slot;
  logic        w_rd;
  logic        w_consume;
  logic        w_done;
  logic [15:0] w_mdb_bits;
  logic [15:0] w_discard_init;
  logic [11:0] w_len_cur;
  logic [11:0] w_part2;
  logic [11:0] w_hf_calc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_len
      assign w_len_arr[gi] = r_len[12*gi +: 12];
    end
  endgenerate

  assign w_slot    = {r_gr, r_ch};
  assign w_len_cur = w_len_arr[w_slot];

  assign w_rd      = (r_state == S_DISCARD) || (r_state == S_SF) || (r_state == S_HF);
  assign w_consume = w_rd & fifo_dout_v;
  // Parser done bits are numbered from the opposite end of the slot index.
  assign w_done    = sf_parser_axiov[2'd3 - w_slot];

  assign w_mdb_bits     = {4'd0, main_data_begin, 3'd0};
  assign w_discard_init = (fifo_sample_count > w_mdb_bits) ? (fifo_sample_count - w_mdb_bits) : 16'd0;

  // A bit accepted in the same cycle as the done pulse belongs to part2.
  assign w_part2   = r_p2cnt + {11'd0, w_consume};
  assign w_hf_calc = (w_len_cur > w_part2) ? (w_len_cur - w_part2) : 12'd0;

  assign sf_parser_flag  = (r_state == S_SF);
  assign hf_decoder_flag = (r_state == S_HF);
  assign fifo_rd_en      = w_rd;
  assign busy            = (r_state != S_IDLE);
  assign gr              = r_gr;
  assign ch              = r_ch;

  always_comb begin
    w_state_next   = r_state;
    w_gr_next      = r_gr;
    w_ch_next      = r_ch;
    w_discard_next = r_discard;
    w_p2cnt_next   = r_p2cnt;
    w_hf_rem_next  = r_hf_rem;
    w_len_load     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_gr_next     = 1'b0;
        w_ch_next     = 1'b0;
        w_p2cnt_next  = 12'd0;
        w_hf_rem_next = 12'd0;
        if (si_valid_in) begin
          w_len_load     = 1'b1;
          w_discard_next = w_discard_init;
          w_state_next   = (w_discard_init != 16'd0) ? S_DISCARD : S_SF;
        end
      end

      S_DISCARD: begin
        if (w_consume) begin
          w_discard_next = r_discard - 16'd1;
          if (r_discard == 16'd1) begin
            w_state_next = S_SF;
          end
        end
      end

      S_SF: begin
        if (w_consume) begin
          w_p2cnt_next = r_p2cnt + 12'd1;
        end
        if (w_done) begin
          w_hf_rem_next = w_hf_calc;
          w_state_next  = (w_hf_calc != 12'd0) ? S_HF : S_ADVANCE;
        end
      end

      S_HF: begin
        if (w_consume) begin
          w_hf_rem_next = r_hf_rem - 12'd1;
          if (r_hf_rem == 12'd1) begin
            w_state_next = S_ADVANCE;
          end
        end
      end

      S_ADVANCE: begin
        w_p2cnt_next = 12'd0;
        if (w_slot == 2'd3) begin
          w_gr_next    = 1'b0;
          w_ch_next    = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          {w_gr_next, w_ch_next} = w_slot + 2'd1;
          w_state_next           = S_SF;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gr      <= 1'b0;
      r_ch      <= 1'b0;
      r_discard <= 16'd0;
      r_p2cnt   <= 12'd0;
      r_hf_rem  <= 12'd0;
      r_len     <= 48'd0;
    end else begin
      r_state   <= w_state_next;
      r_gr      <= w_gr_next;
      r_ch      <= w_ch_next;
      r_discard <= w_discard_next;
      r_p2cnt   <= w_p2cnt_next;
      r_hf_rem  <= w_hf_rem_next;
      if (w_len_load) begin
        r_len <= part2_3_length;
      end
    end
  end

endmodule

// File: tb/tb_fifo_muxer_ctrl.sv
// Bench for fifo_muxer_ctrl: a segment-list model of each frame is checked
// every cycle, plus literal expectations on burst sizes and reset behaviour.
module tb_fifo_muxer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fifo_sample_count;
  logic        fifo_dout_v;
  logic        si_valid_in;
  logic [8:0]  main_data_begin;
  logic [47:0] part2_3_length;
  logic [3:0]  sf_parser_axiov;
  logic        sf_parser_flag;
  logic        hf_decoder_flag;
  logic        gr;
  logic        ch;
  logic        fifo_rd_en;
  logic        busy;

  always #5 clk = ~clk;

  fifo_muxer_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_sample_count (fifo_sample_count),
    .fifo_dout_v       (fifo_dout_v),
    .si_valid_in       (si_valid_in),
    .main_data_begin   (main_data_begin),
    .part2_3_length    (part2_3_length),
    .sf_parser_axiov   (sf_parser_axiov),
    .sf_parser_flag    (sf_parser_flag),
    .hf_decoder_flag   (hf_decoder_flag),
    .gr                (gr),
    .ch                (ch),
    .fifo_rd_en        (fifo_rd_en),
    .busy              (busy)
  );

  int checks = 0;
  int errors = 0;

  // Frame plan: bits each slot's parser takes before signalling done.
  int plan_p2 [4];

  // Model: a frame is a list of segments (discard burst, parser burst,
  // Huffman burst, one-cycle gap), each consumed in order.
  localparam int K_D = 0, K_S = 1, K_H = 2, K_A = 3;
  int seg_kind [16];
  int seg_slot [16];
  int seg_bits [16];
  int seg_n   = 0;
  int seg_idx = 0;
  int model_hf [4];

  // Stimulus-side observations.
  int disc_bits;
  int body_bits;
  int hf_bits [4];
  logic [2:0] first_flags;
  bit timed_out;
  bit aborted;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic add_seg(input int k, input int s, input int b);
    seg_kind[seg_n] = k;
    seg_slot[seg_n] = s;
    seg_bits[seg_n] = b;
    seg_n++;
  endtask

  task automatic build_frame();
    int d;
    int ln;
    int h;
    seg_n   = 0;
    seg_idx = 0;
    d = int'(fifo_sample_count) - 8 * int'(main_data_begin);
    if (d > 0) add_seg(K_D, 0, d);
    for (int s = 0; s < 4; s++) begin
      ln = int'(part2_3_length[12*s +: 12]);
      h  = ln - plan_p2[s];
      model_hf[s] = (h > 0) ? h : 0;
      add_seg(K_S, s, plan_p2[s]);
      if (h > 0) add_seg(K_H, s, h);
      add_seg(K_A, s, 0);
    end
  endtask

  // Compare process: DUT outputs vs. model every cycle out of reset.
  always @(negedge clk) begin
    logic [5:0] e_v;
    logic [5:0] a_v;
    int k;
    int s;
    bit took;
    if (!rst) begin
      seg_n   = 0;
      seg_idx = 0;
    end else begin
      e_v = 6'b0;
      k   = -1;
      s   = 0;
      if (seg_idx < seg_n) begin
        k = seg_kind[seg_idx];
        s = seg_slot[seg_idx];
        e_v[5] = (k == K_S);
        e_v[4] = (k == K_H);
        e_v[3] = (k != K_A);
        e_v[2] = 1'b1;
        e_v[1] = s[1];
        e_v[0] = s[0];
      end
      a_v = {sf_parser_flag, hf_decoder_flag, fifo_rd_en, busy, gr, ch};
      checks++;
      if (a_v !== e_v) begin
        errors++;
        $display("FAIL cycle t=%0t {sf,hf,rd,busy,gr,ch} actual %b required %b", $time, a_v, e_v);
      end
      took = fifo_dout_v && e_v[3];
      if (seg_idx >= seg_n) begin
        if (si_valid_in) build_frame();
      end else begin
        case (k)
          K_A: seg_idx++;
          K_S: begin
            if (seg_bits[seg_idx] == 0) seg_idx++;
            else if (took) begin
              seg_bits[seg_idx]--;
              if (seg_bits[seg_idx] == 0) seg_idx++;
            end
          end
          default: begin
            if (took) begin
              seg_bits[seg_idx]--;
              if (seg_bits[seg_idx] == 0) seg_idx++;
            end
          end
        endcase
        if (seg_idx >= seg_n) begin
          seg_n   = 0;
          seg_idx = 0;
        end
      end
    end
  end

  // Drives one frame, emulating the parsers; optional stall/ignore stimulus
  // and optional abort once slot 0 Huffman has taken abort_at bits.
  task automatic run_frame(input logic [15:0] cnt, input logic [8:0] mdb, input logic [47:0] len,
                           input int q0, input int q1, input int q2, input int q3,
                           input bit extras, input int abort_at);
    int  sf_bits;
    int  prev_slot;
    bit  prev_sf;
    int  stall;
    bit  stall_done;
    int  slot;
    bit  done;
    plan_p2[0] = q0; plan_p2[1] = q1; plan_p2[2] = q2; plan_p2[3] = q3;
    disc_bits = 0; body_bits = 0;
    for (int i = 0; i < 4; i++) hf_bits[i] = 0;
    timed_out = 1'b0; aborted = 1'b0; done = 1'b0;
    sf_bits = 0; prev_slot = -1; prev_sf = 1'b0; stall = 0; stall_done = 1'b0;

    @(posedge clk); #1;
    fifo_sample_count = cnt;
    main_data_begin   = mdb;
    part2_3_length    = len;
    si_valid_in       = 1'b1;
    fifo_dout_v       = 1'b1;
    sf_parser_axiov   = 4'b0;
    @(posedge clk); #1;
    first_flags = {sf_parser_flag, hf_decoder_flag, fifo_rd_en};

    for (int cyc = 0; cyc < 40000; cyc++) begin
      si_valid_in     = 1'b0;
      sf_parser_axiov = 4'b0;
      fifo_dout_v     = 1'b1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      slot = {30'd0, gr, ch};
      if (hf_decoder_flag && slot == 0 && abort_at > 0 && hf_bits[0] == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (sf_parser_flag && (!prev_sf || slot != prev_slot)) sf_bits = 0;
      if (stall > 0) begin
        fifo_dout_v = 1'b0;
        stall--;
      end else if (extras && !stall_done && hf_decoder_flag && slot == 0 && hf_bits[0] == 100) begin
        fifo_dout_v = 1'b0;
        stall       = 49;
        stall_done  = 1'b1;
      end
      if (sf_parser_flag) begin
        if (plan_p2[slot] == 0) begin
          fifo_dout_v = 1'b0;
          sf_parser_axiov[3-slot] = 1'b1;
        end else if (sf_bits + 1 == plan_p2[slot]) begin
          sf_parser_axiov[3-slot] = 1'b1;
        end
        if (extras && slot == 1 && sf_bits == 5) begin
          sf_parser_axiov[3] = 1'b1;
          sf_parser_axiov[0] = 1'b1;
        end
      end
      if (extras && hf_decoder_flag && slot == 1 && hf_bits[1] == 10) begin
        si_valid_in       = 1'b1;
        fifo_sample_count = 16'd100;
        main_data_begin   = 9'd0;
        part2_3_length    = '1;
      end
      if (fifo_rd_en && fifo_dout_v) begin
        if (!sf_parser_flag && !hf_decoder_flag) disc_bits++;
        else begin
          body_bits++;
          if (sf_parser_flag) sf_bits++;
          if (hf_decoder_flag) hf_bits[slot]++;
        end
      end
      prev_sf   = sf_parser_flag;
      prev_slot = slot;
      @(posedge clk); #1;
    end
    if (!done && !aborted) timed_out = 1'b1;
  endtask

  initial begin
    rst               = 1'b0;
    fifo_sample_count = 16'd0;
    fifo_dout_v       = 1'b0;
    si_valid_in       = 1'b0;
    main_data_begin   = 9'd0;
    part2_3_length    = 48'd0;
    sf_parser_axiov   = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_outputs", int'({sf_parser_flag, hf_decoder_flag, fifo_rd_en, busy, gr, ch}), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full frame with discard, stall and ignored inputs.
    run_frame(16'd20000, 9'd491, 48'ha189f7c75c83, 57, 57, 0, 30, 1'b1, 0);
    check_int("f1_timeout", int'(timed_out), 0);
    check_int("f1_first_cycle_sf_hf_rd", int'(first_flags), 3'b001);
    check_int("f1_discarded", disc_bits, 16072);
    check_int("f1_body_bits", body_bits, 11527);
    check_int("f1_hf_s0", hf_bits[0], 3146);
    check_int("f1_hf_s1", hf_bits[1], 3132);
    check_int("f1_hf_s2", hf_bits[2], 2551);
    check_int("f1_hf_s3", hf_bits[3], 2554);
    check_int("f1_model_hf_s0", model_hf[0], 3146);
    check_int("f1_model_hf_s3", model_hf[3], 2554);
    check_int("f1_idle_gr_ch", int'({busy, gr, ch}), 0);

    // Reset in the middle of slot 0 Huffman.
    run_frame(16'd3928, 9'd491, 48'ha189f7c75c83, 57, 57, 0, 30, 1'b0, 20);
    check_int("rst_reached_hf", int'(aborted), 1);
    check_int("rst_hf_bits_before", hf_bits[0], 20);
    rst = 1'b0;
    #1;
    check_int("rst_async_outputs", int'({sf_parser_flag, hf_decoder_flag, fifo_rd_en, busy, gr, ch}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_int("rst_release_idle", int'({sf_parser_flag, hf_decoder_flag, fifo_rd_en, busy, gr, ch}), 0);

    // No discard; saturating and exact-zero Huffman remainders.
    run_frame(16'd3928, 9'd491, {12'd5, 12'd20, 12'd100, 12'd20}, 25, 10, 20, 0, 1'b0, 0);
    check_int("f2_timeout", int'(timed_out), 0);
    check_int("f2_first_cycle_sf_hf_rd", int'(first_flags), 3'b101);
    check_int("f2_discarded", disc_bits, 0);
    check_int("f2_body_bits", body_bits, 150);
    check_int("f2_hf_s0_saturated", hf_bits[0], 0);
    check_int("f2_hf_s1", hf_bits[1], 90);
    check_int("f2_hf_s2", hf_bits[2], 0);
    check_int("f2_hf_s3", hf_bits[3], 5);
    check_int("f2_model_hf_s0", model_hf[0], 0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
